// File: rtl/side_info_parser.sv
// -----------------------------------------------------------------------------
// side_info_parser
//
// Layer III side-information parser. After the frame header has been parsed,
// the upstream stage pulses `start` and then streams the side-information
// bytes. Optionally the 2-byte CRC word is dropped first. Then 17 (mono) or
// 32 (stereo) bytes are collected into a shift register. Every
// granule/channel field is decoded from that bitstream into registered
// outputs, and `axiov` pulses for one cycle when the outputs change.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               header parsed; side info begins with the next byte
//   mono, crc_present   header properties, sampled on start
//   axiiv, axiid        byte stream (valid + byte, MSB first in the bitstream)
//   main_data_begin     9-bit main data back-pointer
//   private_bits        5 bits (mono) or 3 bits zero-extended (stereo)
//   scfsi               per-channel scale-factor selection info
//   part2_3_length ..   per [granule][channel] fields
//   table_select,
//   subblock_gain       per [granule][channel][region/window]
//   axiov               one-cycle pulse: all field outputs updated
//   busy                high while capturing bytes
//   err                 one-cycle pulse when a capture is aborted on timeout
// -----------------------------------------------------------------------------
module side_info_parser #(
    parameter int MAX_CH  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             mono,
    input  logic                             crc_present,
    input  logic                             axiiv,
    input  logic [7:0]                       axiid,
    output logic [8:0]                       main_data_begin,
    output logic [4:0]                       private_bits,
    output logic [MAX_CH-1:0][3:0]           scfsi,
    output logic [1:0][MAX_CH-1:0][11:0]     part2_3_length,
    output logic [1:0][MAX_CH-1:0][8:0]      big_values,
    output logic [1:0][MAX_CH-1:0][7:0]      global_gain,
    output logic [1:0][MAX_CH-1:0][3:0]      scalefac_compress,
    output logic [1:0][MAX_CH-1:0]           window_switching_flag,
    output logic [1:0][MAX_CH-1:0]           mixed_block_flag,
    output logic [1:0][MAX_CH-1:0]           preflag,
    output logic [1:0][MAX_CH-1:0]           scalefac_scale,
    output logic [1:0][MAX_CH-1:0]           count1table_select,
    output logic [1:0][MAX_CH-1:0][1:0]      block_type,
    output logic [1:0][MAX_CH-1:0][2:0][4:0] table_select,
    output logic [1:0][MAX_CH-1:0][2:0][2:0] subblock_gain,
    output logic [1:0][MAX_CH-1:0][7:0]      region0_count,
    output logic [1:0][MAX_CH-1:0][7:0]      region1_count,
    output logic                             axiov,
    output logic                             busy,
    output logic                             err
);

    // Idle counter only has to reach TIMEOUT-1 before the abort fires.
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    // Decoded contents of one 59-bit granule/channel record.
    typedef struct packed {
        logic [11:0]     p23;
        logic [8:0]      bv;
        logic [7:0]      gg;
        logic [3:0]      sfc;
        logic            wsf;
        logic [1:0]      bt;
        logic            mixed;
        logic [2:0][4:0] ts;
        logic [2:0][2:0] sbg;
        logic [7:0]      r0;
        logic [7:0]      r1;
        logic            pre;
        logic            sfs;
        logic            c1t;
    } gc_fields_t;

    state_t          state_reg;
    logic [255:0]    sr_reg;
    logic [5:0]      byte_cnt_reg;
    logic [5:0]      target_reg;
    logic [1:0]      skip_reg;
    logic [IW-1:0]   idle_cnt_reg;
    logic            mono_reg;

    logic [5:0]      byte_cnt_next;
    logic [255:0]    aligned;

    logic [8:0]             dec_mdb;
    logic [4:0]             dec_priv;
    logic [MAX_CH-1:0][3:0] dec_scfsi;
    gc_fields_t             dec_arr [2][MAX_CH];

    assign byte_cnt_next = byte_cnt_reg + 6'd1;

    // A mono frame only fills the low 136 bits of the shift register; move
    // it to the top so bit i of the bitstream is always aligned[255-i].
    assign aligned = mono_reg ? {sr_reg[135:0], 120'd0} : sr_reg;

    // ------------------------------------------------------------------
    // Frame-level fields
    // ------------------------------------------------------------------
    assign dec_mdb  = aligned[255 -: 9];
    assign dec_priv = mono_reg ? aligned[246 -: 5] : {2'b00, aligned[246 -: 3]};

    genvar gi, gc;
    generate
        for (gc = 0; gc < MAX_CH; gc++) begin : g_scfsi
            if (gc == 0) begin : g_ch0
                // mono: bits 14..17, stereo: bits 12..15
                assign dec_scfsi[gc] = mono_reg ? aligned[241 -: 4] : aligned[243 -: 4];
            end else begin : g_ch1
                // stereo only: bits 16..19
                assign dec_scfsi[gc] = mono_reg ? 4'd0 : aligned[239 -: 4];
            end
        end

        // ------------------------------------------------------------------
        // Per granule/channel records. Mono records start at bit 18 and are
        // ordered gr0ch0, gr1ch0. Stereo records start at bit 20 and are
        // ordered gr0ch0, gr0ch1, gr1ch0, gr1ch1.
        // ------------------------------------------------------------------
        for (gi = 0; gi < 2; gi++) begin : g_gr
            for (gc = 0; gc < MAX_CH; gc++) begin : g_ch
                localparam int MONO_POS   = 18 + gi * 59;
                localparam int STEREO_POS = 20 + (gi * 2 + gc) * 59;

                logic [58:0] fld;
                gc_fields_t  dec;

                if (gc == 0) begin : g_sel0
                    assign fld = mono_reg ? aligned[255 - MONO_POS -: 59]
                                          : aligned[255 - STEREO_POS -: 59];
                end else begin : g_sel1
                    // Channel 1 does not exist in mono frames.
                    assign fld = mono_reg ? 59'd0 : aligned[255 - STEREO_POS -: 59];
                end

                // fld[58] is the first bit of the record.
                always_comb begin
                    dec       = '0;
                    dec.p23   = fld[58:47];
                    dec.bv    = fld[46:38];
                    dec.gg    = fld[37:30];
                    dec.sfc   = fld[29:26];
                    dec.wsf   = fld[25];
                    dec.pre   = fld[2];
                    dec.sfs   = fld[1];
                    dec.c1t   = fld[0];
                    if (fld[25]) begin
                        dec.bt     = fld[24:23];
                        dec.mixed  = fld[22];
                        dec.ts[0]  = fld[21:17];
                        dec.ts[1]  = fld[16:12];
                        dec.ts[2]  = 5'd0;
                        dec.sbg[0] = fld[11:9];
                        dec.sbg[1] = fld[8:6];
                        dec.sbg[2] = fld[5:3];
                        // Region boundaries are implied for switched windows:
                        // pure short blocks use 8, everything else 7.
                        dec.r0     = (fld[24:23] == 2'd2 && !fld[22]) ? 8'd8 : 8'd7;
                        dec.r1     = 8'd36;
                    end else begin
                        dec.ts[0]  = fld[24:20];
                        dec.ts[1]  = fld[19:15];
                        dec.ts[2]  = fld[14:10];
                        dec.r0     = {4'd0, fld[9:6]};
                        dec.r1     = {5'd0, fld[5:3]};
                    end
                end

                assign dec_arr[gi][gc] = dec;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg             <= ST_IDLE;
            sr_reg                <= '0;
            byte_cnt_reg          <= '0;
            target_reg            <= '0;
            skip_reg              <= '0;
            idle_cnt_reg          <= '0;
            mono_reg              <= 1'b0;
            axiov                 <= 1'b0;
            busy                  <= 1'b0;
            err                   <= 1'b0;
            main_data_begin       <= '0;
            private_bits          <= '0;
            scfsi                 <= '0;
            part2_3_length        <= '0;
            big_values            <= '0;
            global_gain           <= '0;
            scalefac_compress     <= '0;
            window_switching_flag <= '0;
            mixed_block_flag      <= '0;
            preflag               <= '0;
            scalefac_scale        <= '0;
            count1table_select    <= '0;
            block_type            <= '0;
            table_select          <= '0;
            subblock_gain         <= '0;
            region0_count         <= '0;
            region1_count         <= '0;
        end else begin
            axiov <= 1'b0;
            err   <= 1'b0;

            if (state_reg == ST_DONE) begin
                main_data_begin <= dec_mdb;
                private_bits    <= dec_priv;
                scfsi           <= dec_scfsi;
                for (int g = 0; g < 2; g++) begin
                    for (int c = 0; c < MAX_CH; c++) begin
                        part2_3_length[g][c]        <= dec_arr[g][c].p23;
                        big_values[g][c]            <= dec_arr[g][c].bv;
                        global_gain[g][c]           <= dec_arr[g][c].gg;
                        scalefac_compress[g][c]     <= dec_arr[g][c].sfc;
                        window_switching_flag[g][c] <= dec_arr[g][c].wsf;
                        mixed_block_flag[g][c]      <= dec_arr[g][c].mixed;
                        block_type[g][c]            <= dec_arr[g][c].bt;
                        table_select[g][c]          <= dec_arr[g][c].ts;
                        subblock_gain[g][c]         <= dec_arr[g][c].sbg;
                        region0_count[g][c]         <= dec_arr[g][c].r0;
                        region1_count[g][c]         <= dec_arr[g][c].r1;
                        preflag[g][c]               <= dec_arr[g][c].pre;
                        scalefac_scale[g][c]        <= dec_arr[g][c].sfs;
                        count1table_select[g][c]    <= dec_arr[g][c].c1t;
                    end
                end
                axiov     <= 1'b1;
                state_reg <= ST_IDLE;
            end

            // start wins over everything else: from IDLE it begins a capture,
            // mid-capture it resynchronises and drops the partial frame. A
            // byte arriving in the same cycle belongs to the header side and
            // is not captured.
            if (start) begin
                state_reg    <= ST_CAPTURE;
                busy         <= 1'b1;
                mono_reg     <= (MAX_CH == 1) ? 1'b1 : mono;
                target_reg   <= (MAX_CH == 1 || mono) ? 6'd17 : 6'd32;
                skip_reg     <= crc_present ? 2'd2 : 2'd0;
                byte_cnt_reg <= '0;
                idle_cnt_reg <= '0;
                sr_reg       <= '0;
            end else if (state_reg == ST_CAPTURE) begin
                if (axiiv) begin
                    idle_cnt_reg <= '0;
                    if (skip_reg != 2'd0) begin
                        skip_reg <= skip_reg - 2'd1;
                    end else begin
                        sr_reg       <= {sr_reg[247:0], axiid};
                        byte_cnt_reg <= byte_cnt_next;
                        if (byte_cnt_next == target_reg) begin
                            state_reg <= ST_DONE;
                            busy      <= 1'b0;
                        end
                    end
                end else if (idle_cnt_reg == IW'(TIMEOUT - 1)) begin
                    err       <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= ST_IDLE;
                end else begin
                    idle_cnt_reg <= idle_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_side_info_parser.sv
module tb_side_info_parser;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst_n, start, mono, crc_present, axiiv;
    logic [7:0] axiid;
    logic [8:0] main_data_begin;
    logic [4:0] private_bits;
    logic [1:0][3:0] scfsi;
    logic [1:0][1:0][11:0] part2_3_length;
    logic [1:0][1:0][8:0] big_values;
    logic [1:0][1:0][7:0] global_gain;
    logic [1:0][1:0][3:0] scalefac_compress;
    logic [1:0][1:0] window_switching_flag, mixed_block_flag, preflag;
    logic [1:0][1:0] scalefac_scale, count1table_select;
    logic [1:0][1:0][1:0] block_type;
    logic [1:0][1:0][2:0][4:0] table_select;
    logic [1:0][1:0][2:0][2:0] subblock_gain;
    logic [1:0][1:0][7:0] region0_count, region1_count;
    logic axiov, busy, err;

    side_info_parser #(.MAX_CH(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mono(mono),
        .crc_present(crc_present), .axiiv(axiiv), .axiid(axiid),
        .main_data_begin(main_data_begin), .private_bits(private_bits),
        .scfsi(scfsi), .part2_3_length(part2_3_length), .big_values(big_values),
        .global_gain(global_gain), .scalefac_compress(scalefac_compress),
        .window_switching_flag(window_switching_flag),
        .mixed_block_flag(mixed_block_flag), .preflag(preflag),
        .scalefac_scale(scalefac_scale), .count1table_select(count1table_select),
        .block_type(block_type), .table_select(table_select),
        .subblock_gain(subblock_gain), .region0_count(region0_count),
        .region1_count(region1_count), .axiov(axiov), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int axiov_cnt = 0;

    always @(negedge clk) if (axiov) axiov_cnt++;

    // Reference model: the frame as a plain byte array, read field by field
    // with a sequential bit reader.
    logic [7:0] fb [32];
    int rp;
    int e_mdb, e_priv;
    int e_scfsi [2];
    int e_p23 [2][2], e_bv [2][2], e_gg [2][2], e_sfc [2][2], e_wsf [2][2];
    int e_mix [2][2], e_bt [2][2], e_r0 [2][2], e_r1 [2][2];
    int e_pre [2][2], e_sfs [2][2], e_c1t [2][2];
    int e_ts [2][2][3], e_sbg [2][2][3];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rd(input int n);
        int v = 0;
        for (int i = 0; i < n; i++) begin
            v = (v << 1) | int'(fb[rp / 8][7 - (rp % 8)]);
            rp++;
        end
        return v;
    endfunction

    task automatic put_bits(input int pos, input int w, input int val);
        for (int i = 0; i < w; i++)
            fb[(pos + i) / 8][7 - ((pos + i) % 8)] = val[w - 1 - i];
    endtask

    task automatic model_clear();
        e_mdb = 0; e_priv = 0;
        for (int c = 0; c < 2; c++) e_scfsi[c] = 0;
        for (int g = 0; g < 2; g++) for (int c = 0; c < 2; c++) begin
            e_p23[g][c] = 0; e_bv[g][c] = 0; e_gg[g][c] = 0; e_sfc[g][c] = 0;
            e_wsf[g][c] = 0; e_mix[g][c] = 0; e_bt[g][c] = 0; e_r0[g][c] = 0;
            e_r1[g][c] = 0; e_pre[g][c] = 0; e_sfs[g][c] = 0; e_c1t[g][c] = 0;
            for (int k = 0; k < 3; k++) begin e_ts[g][c][k] = 0; e_sbg[g][c][k] = 0; end
        end
    endtask

    task automatic model_decode(input bit m);
        int nch;
        nch = m ? 1 : 2;
        model_clear();
        rp = 0;
        e_mdb  = rd(9);
        e_priv = rd(m ? 5 : 3);
        for (int c = 0; c < nch; c++) e_scfsi[c] = rd(4);
        for (int g = 0; g < 2; g++) for (int c = 0; c < nch; c++) begin
            e_p23[g][c] = rd(12); e_bv[g][c] = rd(9);
            e_gg[g][c]  = rd(8);  e_sfc[g][c] = rd(4);
            e_wsf[g][c] = rd(1);
            if (e_wsf[g][c] == 1) begin
                e_bt[g][c]  = rd(2); e_mix[g][c] = rd(1);
                e_ts[g][c][0] = rd(5); e_ts[g][c][1] = rd(5);
                for (int k = 0; k < 3; k++) e_sbg[g][c][k] = rd(3);
                e_r0[g][c] = (e_bt[g][c] == 2 && e_mix[g][c] == 0) ? 8 : 7;
                e_r1[g][c] = 36;
            end else begin
                for (int k = 0; k < 3; k++) e_ts[g][c][k] = rd(5);
                e_r0[g][c] = rd(4); e_r1[g][c] = rd(3);
            end
            e_pre[g][c] = rd(1); e_sfs[g][c] = rd(1); e_c1t[g][c] = rd(1);
        end
    endtask

    task automatic compare_all(input string tag);
        string t;
        check_val({tag, "_mdb"}, 32'(main_data_begin), e_mdb);
        check_val({tag, "_priv"}, 32'(private_bits), e_priv);
        for (int c = 0; c < 2; c++)
            check_val($sformatf("%s_scfsi%0d", tag, c), 32'(scfsi[c]), e_scfsi[c]);
        for (int g = 0; g < 2; g++) for (int c = 0; c < 2; c++) begin
            t = $sformatf("%s_g%0dc%0d", tag, g, c);
            check_val({t, "_p23"}, 32'(part2_3_length[g][c]), e_p23[g][c]);
            check_val({t, "_bv"},  32'(big_values[g][c]), e_bv[g][c]);
            check_val({t, "_gg"},  32'(global_gain[g][c]), e_gg[g][c]);
            check_val({t, "_sfc"}, 32'(scalefac_compress[g][c]), e_sfc[g][c]);
            check_val({t, "_wsf"}, 32'(window_switching_flag[g][c]), e_wsf[g][c]);
            check_val({t, "_mix"}, 32'(mixed_block_flag[g][c]), e_mix[g][c]);
            check_val({t, "_bt"},  32'(block_type[g][c]), e_bt[g][c]);
            check_val({t, "_r0"},  32'(region0_count[g][c]), e_r0[g][c]);
            check_val({t, "_r1"},  32'(region1_count[g][c]), e_r1[g][c]);
            check_val({t, "_pre"}, 32'(preflag[g][c]), e_pre[g][c]);
            check_val({t, "_sfs"}, 32'(scalefac_scale[g][c]), e_sfs[g][c]);
            check_val({t, "_c1t"}, 32'(count1table_select[g][c]), e_c1t[g][c]);
            for (int k = 0; k < 3; k++) begin
                check_val($sformatf("%s_ts%0d", t, k), 32'(table_select[g][c][k]), e_ts[g][c][k]);
                check_val($sformatf("%s_sbg%0d", t, k), 32'(subblock_gain[g][c][k]), e_sbg[g][c][k]);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gapmax);
        int gap;
        gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        for (int i = 0; i < gap; i++) begin
            axiid = 8'($urandom);
            tick();
        end
        axiiv = 1'b1;
        axiid = b;
        tick();
        axiiv = 1'b0;
    endtask

    task automatic pulse_start(input bit m, input bit crc);
        start = 1'b1; mono = m; crc_present = crc;
        axiiv = 1'b1; axiid = 8'hA5;   // coincident byte must be dropped
        tick();
        start = 1'b0; axiiv = 1'b0;
    endtask

    task automatic run_frame(input bit m, input bit crc, input int gapmax, input string tag);
        int n;
        n = m ? 17 : 32;
        pulse_start(m, crc);
        check_val({tag, "_busy_on"}, 32'(busy), 1);
        if (crc) begin
            send_byte(8'hDE, gapmax);
            send_byte(8'hAD, gapmax);
        end
        for (int i = 0; i < n; i++) send_byte(fb[i], gapmax);
        check_val({tag, "_busy_off"}, 32'(busy), 0);
        check_val({tag, "_axiov_early"}, 32'(axiov), 0);
        tick();
        check_val({tag, "_axiov"}, 32'(axiov), 1);
        model_decode(m);
        compare_all(tag);
        tick();
        check_val({tag, "_axiov_pulse"}, 32'(axiov), 0);
        $display("frame %s mono=%0d crc=%0d mdb=%0d p23_00=0x%0h", tag, m, crc,
                 main_data_begin, part2_3_length[0][0]);
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < 32; i++) fb[i] = rnd ? 8'($urandom) : 8'h00;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;
        bit seen;
        rst_n = 1'b0; start = 1'b0; mono = 1'b0; crc_present = 1'b0;
        axiiv = 1'b0; axiid = 8'h00;
        repeat (3) tick();
        rst_n = 1'b1;
        // bytes while idle are ignored
        axiiv = 1'b1; axiid = 8'hFF; tick(); axiiv = 1'b0;
        tick();
        model_clear();
        check_val("rst_axiov", 32'(axiov), 0);
        check_val("rst_busy", 32'(busy), 0);
        check_val("rst_err", 32'(err), 0);
        compare_all("rst");

        // directed stereo frame
        fill(0);
        fb[0] = 8'hFF; fb[1] = 8'h80; fb[2] = 8'h0A; fb[3] = 8'hBC;
        run_frame(0, 0, 2, "st_dir");
        check_val("st_dir_mdb511", 32'(main_data_begin), 511);
        check_val("st_dir_p23abc", 32'(part2_3_length[0][0]), 32'hABC);

        // switched-window short block on gr1ch1 (record starts at bit 197)
        for (int mx = 0; mx < 2; mx++) begin
            fill(1);
            put_bits(197 + 33, 1, 1);
            put_bits(197 + 34, 2, 2);
            put_bits(197 + 36, 1, mx);
            run_frame(0, 0, 1, $sformatf("wsf_mx%0d", mx));
            check_val("wsf_r0", 32'(region0_count[1][1]), (mx == 0) ? 8 : 7);
            check_val("wsf_r1", 32'(region1_count[1][1]), 36);
            check_val("wsf_ts2", 32'(table_select[1][1][2]), 0);
        end

        // mono with CRC word
        fill(0);
        fb[0] = 8'h80;
        run_frame(1, 1, 2, "mono_crc");
        check_val("mono_mdb256", 32'(main_data_begin), 256);
        check_val("mono_scfsi1", 32'(scfsi[1]), 0);
        check_val("mono_p23_01", 32'(part2_3_length[0][1]), 0);
        check_val("mono_gg_11", 32'(global_gain[1][1]), 0);

        // randomized frames
        for (int f = 0; f < 16; f++) begin
            fill(1);
            run_frame(1'($urandom), 1'($urandom), (f == 5) ? 50 : 3, $sformatf("rnd%0d", f));
        end

        // timeout abort after 10 bytes
        axiov_cnt = 0;
        pulse_start(0, 0);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 2);
        c = 0; seen = 0;
        while (!seen && c < TO + 8) begin
            tick();
            c++;
            if (err) seen = 1;
        end
        check_val("to_seen", 32'(seen), 1);
        check_val("to_cycles", c, TO);
        check_val("to_busy", 32'(busy), 0);
        tick();
        check_val("to_err_pulse", 32'(err), 0);
        check_val("to_no_axiov", axiov_cnt, 0);
        compare_all("to_hold");
        $display("timeout abort after %0d idle cycles", c);

        // resync: 20 bytes then a fresh start and full frame
        axiov_cnt = 0;
        pulse_start(0, 0);
        for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1);
        fill(1);
        run_frame(0, 0, 1, "resync");
        check_val("resync_one_axiov", axiov_cnt, 1);

        // reset mid-capture
        pulse_start(0, 1);
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        model_clear();
        check_val("mrst_busy", 32'(busy), 0);
        compare_all("mrst");
        fill(1);
        run_frame(0, 1, 2, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
